// File: rtl/d_reg_pkg.sv
// Shared decode constants, exception codes and the F/D pipeline register layout.
// Imported by the F/D register and by the branch/jump pre-decoder.
package d_reg_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] EXC_NONE   = 5'd0;
    localparam logic [4:0] EXC_ADEL   = 5'd4;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc_code;
        logic        bd;
        logic        valid;
        logic        is_bj;
    } d_stage_t;

endpackage

// File: rtl/d_reg_bj_predec.sv
// Combinational pre-decoder: flags any branch or jump encoding.
// Shared by later pipeline stages that need the same classification.
module d_reg_bj_predec
    import d_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic        isBJ
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        isBJ = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J, OP_JAL: isBJ = 1'b1;
            OP_SPECIAL:              isBJ = (funct == FN_JR) || (funct == FN_JALR);
            default:                 isBJ = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_reg.sv
// F/D pipeline register: flush to the handler on req, hold on stall, else load.
// Tracks delay-slot membership from the previous instruction's branch flag.
module d_reg
    import d_reg_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_instr,
    input  logic [31:0] F_pc,
    input  logic        F_excAdEL,
    input  logic        stall,
    input  logic        req,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [4:0]  D_excCode,
    output logic        D_BD,
    output logic        D_valid,
    output logic        D_isBJ
);

    d_stage_t d_q;
    d_stage_t d_load;
    d_stage_t d_flush;
    d_stage_t d_reset;
    logic     f_is_bj;

    d_reg_bj_predec u_predec (
        .instr (F_instr),
        .isBJ  (f_is_bj)
    );

    always_comb begin
        d_reset          = '0;
        d_reset.pc       = RESET_PC;

        d_flush          = '0;
        d_flush.pc       = HANDLER_PC;

        d_load           = '0;
        d_load.instr     = F_instr;
        d_load.pc        = F_pc;
        d_load.exc_code  = F_excAdEL ? EXC_ADEL : EXC_NONE;
        // Delay-slot flag comes from what D held before this edge, even for a faulting fetch.
        d_load.bd        = d_q.valid & d_q.is_bj;
        d_load.valid     = 1'b1;
        d_load.is_bj     = f_is_bj & ~F_excAdEL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= d_reset;
        end else if (req) begin
            d_q <= d_flush;
        end else if (!stall) begin
            d_q <= d_load;
        end
    end

    assign D_instr   = d_q.instr;
    assign D_pc      = d_q.pc;
    assign D_excCode = d_q.exc_code;
    assign D_BD      = d_q.bd;
    assign D_valid   = d_q.valid;
    assign D_isBJ    = d_q.is_bj;

endmodule

// File: tb/tb_d_reg.sv
// Self-checking bench for d_reg: vector table plus hand-written reset/stall/flush sequences.
// Expected D-stage contents are queued when stimulus is driven and compared after the edge.
module tb_d_reg;

    localparam logic [31:0] BEQ    = 32'h1000_0003;
    localparam logic [31:0] BNE    = 32'h1400_0002;
    localparam logic [31:0] BLEZ   = 32'h1800_0001;
    localparam logic [31:0] BGTZ   = 32'h1C00_0001;
    localparam logic [31:0] BLTZ   = 32'h0400_0002;
    localparam logic [31:0] JMP    = 32'h0800_0C00;
    localparam logic [31:0] JAL    = 32'h0C00_0C00;
    localparam logic [31:0] JR     = 32'h03E0_0008;
    localparam logic [31:0] JALR   = 32'h0020_F809;
    localparam logic [31:0] ADDU   = 32'h0022_1821;
    localparam logic [31:0] MOVZ   = 32'h0022_180A;
    localparam logic [31:0] LW     = 32'h8C01_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  code;
        logic        bd;
        logic        valid;
        logic        bj;
    } out_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic        F_excAdEL;
    logic        stall;
    logic        req;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [4:0]  D_excCode;
    logic        D_BD;
    logic        D_valid;
    logic        D_isBJ;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    d_reg #(.HANDLER_PC(32'h0000_4180)) dut (
        .clk       (clk),
        .reset     (reset),
        .F_instr   (F_instr),
        .F_pc      (F_pc),
        .F_excAdEL (F_excAdEL),
        .stall     (stall),
        .req       (req),
        .D_instr   (D_instr),
        .D_pc      (D_pc),
        .D_excCode (D_excCode),
        .D_BD      (D_BD),
        .D_valid   (D_valid),
        .D_isBJ    (D_isBJ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [31:0] i, input logic [31:0] p, input logic [4:0] c,
                                input logic b, input logic v, input logic j);
        out_t o;
        o.instr = i; o.pc = p; o.code = c; o.bd = b; o.valid = v; o.bj = j;
        return o;
    endfunction

    task automatic add(input logic s, input logic r, input logic [31:0] i, input logic [31:0] p,
                       input logic e, input out_t x);
        vec_t v;
        v.stall = s; v.req = r; v.instr = i; v.pc = p; v.exc = e; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = {D_instr, D_pc, D_excCode, D_BD, D_valid, D_isBJ};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got instr=%h pc=%h exc=%0d bd=%b valid=%b isbj=%b, expected instr=%h pc=%h exc=%0d bd=%b valid=%b isbj=%b",
                     name, a.instr, a.pc, a.code, a.bd, a.valid, a.bj,
                     e.instr, e.pc, e.code, e.bd, e.valid, e.bj);
        end
    endtask

    task automatic step(input string name, input logic s, input logic r, input logic [31:0] i,
                        input logic [31:0] p, input logic e, input out_t x);
        stall = s; req = r; F_instr = i; F_pc = p; F_excAdEL = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, expected one pending entry", name);
        end else begin
            check(name, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0;
        F_instr = LW; F_pc = 32'h0000_1234; F_excAdEL = 1'b0;

        // normal loads, delay slots, jr/nop pattern, faulting fetches
        add(0, 0, BEQ,  32'h3000, 0, mk(BEQ,  32'h3000, 0, 0, 1, 1));
        add(0, 0, ADDU, 32'h3004, 0, mk(ADDU, 32'h3004, 0, 1, 1, 0));
        add(0, 0, JR,   32'h3008, 0, mk(JR,   32'h3008, 0, 0, 1, 1));
        add(0, 0, NOP,  32'h300C, 0, mk(NOP,  32'h300C, 0, 1, 1, 0));
        add(0, 0, NOP,  32'h3010, 0, mk(NOP,  32'h3010, 0, 0, 1, 0));
        add(0, 0, NOP,  32'h3001, 1, mk(NOP,  32'h3001, 4, 0, 1, 0));
        add(0, 0, JMP,  32'h3018, 1, mk(JMP,  32'h3018, 4, 0, 1, 0));
        add(0, 0, ADDU, 32'h301C, 0, mk(ADDU, 32'h301C, 0, 0, 1, 0));
        add(0, 0, JAL,  32'h3020, 0, mk(JAL,  32'h3020, 0, 0, 1, 1));
        add(0, 0, NOP,  32'h3025, 1, mk(NOP,  32'h3025, 4, 1, 1, 0));
        add(0, 0, BNE,  32'h3028, 0, mk(BNE,  32'h3028, 0, 0, 1, 1));
        // three stalled cycles with F changing, then release
        add(1, 0, LW,   32'h302C, 0, mk(BNE,  32'h3028, 0, 0, 1, 1));
        add(1, 0, ADDU, 32'h3030, 0, mk(BNE,  32'h3028, 0, 0, 1, 1));
        add(1, 0, JMP,  32'h3034, 1, mk(BNE,  32'h3028, 0, 0, 1, 1));
        add(0, 0, ADDU, 32'h3038, 0, mk(ADDU, 32'h3038, 0, 1, 1, 0));
        add(0, 0, JALR, 32'h303C, 0, mk(JALR, 32'h303C, 0, 0, 1, 1));
        add(0, 1, LW,   32'h3040, 0, mk(NOP,  32'h4180, 0, 0, 0, 0));
        add(0, 0, BLEZ, 32'h4180, 0, mk(BLEZ, 32'h4180, 0, 0, 1, 1));
        add(0, 0, BGTZ, 32'h4184, 0, mk(BGTZ, 32'h4184, 0, 1, 1, 1));
        add(0, 0, BLTZ, 32'h4188, 0, mk(BLTZ, 32'h4188, 0, 1, 1, 1));
        add(0, 0, JMP,  32'h418C, 0, mk(JMP,  32'h418C, 0, 1, 1, 1));
        add(0, 0, MOVZ, 32'h4190, 0, mk(MOVZ, 32'h4190, 0, 1, 1, 0));
        add(0, 0, LW,   32'h4194, 0, mk(LW,   32'h4194, 0, 0, 1, 0));
        add(0, 0, JAL,  32'h4198, 0, mk(JAL,  32'h4198, 0, 0, 1, 1));
        // flush wins over stall while D holds jal; bubble then holds under stall
        add(1, 1, ADDU, 32'h419C, 0, mk(NOP,  32'h4180, 0, 0, 0, 0));
        add(1, 0, BEQ,  32'h41A0, 0, mk(NOP,  32'h4180, 0, 0, 0, 0));
        add(0, 0, ADDU, 32'h41A0, 0, mk(ADDU, 32'h41A0, 0, 0, 1, 0));

        #12;
        check("reset_state", mk(0, 32'h3000, 0, 0, 0, 0));
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            step($sformatf("vec%0d", k), vecs[k].stall, vecs[k].req, vecs[k].instr,
                 vecs[k].pc, vecs[k].exc, vecs[k].exp);
        end

        // asynchronous reset between edges, then held across an edge with req and stall
        step("pre_async", 0, 0, BEQ, 32'h5000, 0, mk(BEQ, 32'h5000, 0, 0, 1, 1));
        #2 reset = 1'b1;
        #1 check("async_reset", mk(0, 32'h3000, 0, 0, 0, 0));
        step("reset_over_req_stall", 1, 1, JAL, 32'h5004, 0, mk(0, 32'h3000, 0, 0, 0, 0));
        #2 reset = 1'b0;
        step("first_edge_stall", 1, 0, JAL, 32'h5008, 0, mk(0, 32'h3000, 0, 0, 0, 0));
        step("post_reset_load", 0, 0, JAL, 32'h6000, 0, mk(JAL, 32'h6000, 0, 0, 1, 1));
        step("stall_hold_jal", 1, 0, ADDU, 32'h6004, 0, mk(JAL, 32'h6000, 0, 0, 1, 1));
        #2 reset = 1'b1;
        #1 check("reset_mid_stall", mk(0, 32'h3000, 0, 0, 0, 0));
        #2 reset = 1'b0;
        step("bd_cleared_by_reset", 0, 0, ADDU, 32'h6004, 0, mk(ADDU, 32'h6004, 0, 0, 1, 0));

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
